// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tone_pkg
//  Description : Shared definitions for the tone period meter. Holds the
//                default preset width, the measurement state encoding and a
//                helper that sizes the half-period counter from the timeout.
//  Revision    : 1.0  initial release
// ============================================================================
package tone_pkg;

    localparam int c_DEFAULT_PRESET_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } tone_state_e;

    // Counter must be able to hold the value TIMEOUT itself (saturation point).
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_period_meter_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : edge_sync
//  Description : Synchronises the incoming tone through SYNC_STAGES flops and
//                flags every level change (rising or falling) as a one-cycle
//                edge strobe.
//  Ports       : clk     system clock
//                rst     synchronous active-high reset
//                i_tone  asynchronous square wave
//                o_edge  high for one cycle after each synchronised toggle
//  Revision    : 1.0  initial release
// ============================================================================
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tone,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_tone_d;
    logic                   w_tone_s;

    generate
        if (SYNC_STAGES == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) r_sync <= '0;
                else     r_sync <= i_tone;
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (rst) r_sync <= '0;
                else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_tone};
            end
        end
    endgenerate

    assign w_tone_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) r_tone_d <= 1'b0;
        else     r_tone_d <= w_tone_s;
    end

    assign o_edge = w_tone_s ^ r_tone_d;

endmodule
`default_nettype wire

// File: rtl/tone_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tone_period_meter
//  Description : Measures the half-period of a square wave and recovers the
//                divider preset that produced it (half-period = preset + 1).
//                Locks after two consecutive matching half-periods and flags
//                loss of signal when no edge arrives for TIMEOUT cycles.
//  Ports       : clk           system clock
//                rst           synchronous active-high reset
//                tone_in       square wave under measurement
//                meas_preset   last locked preset (half-period - 1)
//                preset_valid  one-cycle pulse on each new lock
//                locked        high while consecutive half-periods match
//                silent        one-cycle pulse when signal is lost while locked
//  Revision    : 1.0  initial release
// ============================================================================
module tone_period_meter
    import tone_pkg::*;
#(
    parameter int PRESET_W    = c_DEFAULT_PRESET_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tone_in,
    output logic [PRESET_W-1:0] meas_preset,
    output logic                preset_valid,
    output logic                locked,
    output logic                silent
);

    localparam int                 c_CNT_W   = cnt_width(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_MAX_HP  = c_CNT_W'(2 ** PRESET_W);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    logic                w_edge;
    logic                w_in_range;
    logic                w_timeout;
    logic                w_match;
    logic [c_CNT_W-1:0]  r_hp_cnt;
    logic [c_CNT_W-1:0]  r_cand;
    tone_state_e         r_state;
    logic [PRESET_W-1:0] r_meas_preset;
    logic                r_preset_valid;
    logic                r_locked;
    logic                r_silent;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .i_tone (tone_in),
        .o_edge (w_edge)
    );

    // r_hp_cnt in an edge cycle is the length of the interval just closed.
    assign w_in_range = (r_hp_cnt <= c_MAX_HP);
    assign w_timeout  = (r_hp_cnt == c_TIMEOUT);
    assign w_match    = (r_hp_cnt == r_cand);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hp_cnt       <= '0;
            r_cand         <= '0;
            r_state        <= IDLE;
            r_meas_preset  <= '0;
            r_preset_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_silent       <= 1'b0;
        end else begin
            r_preset_valid <= 1'b0;
            r_silent       <= 1'b0;

            if (w_edge)          r_hp_cnt <= c_ONE;
            else if (!w_timeout) r_hp_cnt <= r_hp_cnt + c_ONE;

            // An edge takes precedence over a coincident timeout.
            if (w_edge) begin
                case (r_state)
                    IDLE: begin
                        r_state <= FIRST;
                    end
                    FIRST: begin
                        // The first interval after IDLE is partial; only its
                        // successor seeds the candidate.
                        if (w_in_range) begin
                            r_cand  <= r_hp_cnt;
                            r_state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (!w_in_range) begin
                            r_state <= FIRST;
                        end else if (w_match) begin
                            r_state        <= LOCKED;
                            r_locked       <= 1'b1;
                            r_meas_preset  <= PRESET_W'(r_hp_cnt - c_ONE);
                            r_preset_valid <= 1'b1;
                        end else begin
                            r_cand <= r_hp_cnt;
                        end
                    end
                    LOCKED: begin
                        // A mismatch (including out of range) reseeds the
                        // candidate; an out-of-range value is then rejected
                        // by CHECK on the following edge.
                        if (!w_match) begin
                            r_cand   <= r_hp_cnt;
                            r_state  <= CHECK;
                            r_locked <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end else if (w_timeout) begin
                if (r_state == LOCKED) r_silent <= 1'b1;
                r_state  <= IDLE;
                r_locked <= 1'b0;
            end
        end
    end

    assign meas_preset  = r_meas_preset;
    assign preset_valid = r_preset_valid;
    assign locked       = r_locked;
    assign silent       = r_silent;

endmodule
`default_nettype wire

// File: tb/tb_tone_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tone_period_meter
//  Description : Self-checking bench for tone_period_meter. A behavioural
//                model derived from edge timestamps predicts the outputs every
//                cycle; directed scenarios add literal end-of-test checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tone_period_meter;

    localparam int c_PW = 8;
    localparam int c_S  = 2;
    localparam int c_T  = 512;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tone_in = 1'b0;
    logic [c_PW-1:0] meas_preset;
    logic            preset_valid;
    logic            locked;
    logic            silent;

    int errors = 0;
    int checks = 0;

    tone_period_meter #(
        .PRESET_W    (c_PW),
        .SYNC_STAGES (c_S),
        .TIMEOUT     (c_T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tone_in      (tone_in),
        .meas_preset  (meas_preset),
        .preset_valid (preset_valid),
        .locked       (locked),
        .silent       (silent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model phases: 0 idle, 1 discarding first interval, 2 candidate held,
    // 3 locked. Detection of a tone change happens c_S cycles after it is
    // sampled; the interval is the gap between consecutive detections.
    bit  hist [0:c_S];
    int  since;
    int  phase;
    int  cand;
    int  m_preset, m_valid, m_locked, m_silent;
    bit  started = 0;
    int  cyc = 0;
    int  vcnt = 0;
    int  scnt = 0;
    int  t_sil = 0;

    task automatic model_step();
        bit ev;
        int len;
        if (rst) begin
            for (int i = 0; i <= c_S; i++) hist[i] = 1'b0;
            since = 0; phase = 0; cand = 0;
            m_preset = 0; m_valid = 0; m_locked = 0; m_silent = 0;
            started = 1;
        end else if (started) begin
            ev  = (hist[c_S-1] != hist[c_S]);
            len = since;
            m_valid  = 0;
            m_silent = 0;
            if (ev) begin
                if (phase == 0) phase = 1;
                else if (phase == 1) begin
                    if (len <= 2 ** c_PW) begin cand = len; phase = 2; end
                end else if (phase == 2) begin
                    if (len > 2 ** c_PW) phase = 1;
                    else if (len == cand) begin
                        phase = 3; m_preset = len - 1; m_valid = 1;
                    end else cand = len;
                end else begin
                    if (len != cand) begin cand = len; phase = 2; end
                end
            end else if (since == c_T) begin
                if (phase == 3) m_silent = 1;
                phase = 0;
            end
            since = ev ? 1 : ((since < c_T) ? since + 1 : c_T);
            for (int i = c_S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = tone_in;
            m_locked = (phase == 3) ? 1 : 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            if (started) begin
                check("meas_preset", int'(meas_preset), m_preset);
                check("preset_valid", int'(preset_valid), m_valid);
                check("locked", int'(locked), m_locked);
                check("silent", int'(silent), m_silent);
                if (preset_valid === 1'b1) vcnt++;
                if (silent === 1'b1) begin scnt++; t_sil = cyc; end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tone_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic toggle(input int period, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (period) @(negedge clk);
            tone_in = ~tone_in;
        end
    endtask

    initial begin
        int v0, s0, t_tog;

        // 1: preset 4
        do_reset();
        check("reset_preset", int'(meas_preset), 0);
        check("reset_locked", int'(locked), 0);
        v0 = vcnt;
        toggle(5, 10);
        repeat (8) @(negedge clk);
        check("t1_pulses", vcnt - v0, 1);
        check("t1_preset", int'(meas_preset), 4);
        check("t1_model_preset", m_preset, 4);
        check("t1_locked", int'(locked), 1);

        // 2: preset 9 then every 2
        do_reset();
        v0 = vcnt;
        toggle(10, 6);
        repeat (2) @(negedge clk);
        check("t2a_preset", int'(meas_preset), 9);
        toggle(2, 4);
        repeat (8) @(negedge clk);
        check("t2_pulses", vcnt - v0, 2);
        check("t2_preset", int'(meas_preset), 1);
        check("t2_locked", int'(locked), 1);

        // 3: extremes of range
        do_reset();
        toggle(1, 6);
        repeat (6) @(negedge clk);
        check("t3_p0", int'(meas_preset), 0);
        check("t3_p0_locked", int'(locked), 1);
        toggle(256, 4);
        repeat (6) @(negedge clk);
        check("t3_p255", int'(meas_preset), 255);
        check("t3_p255_model", m_preset, 255);
        do_reset();
        v0 = vcnt;
        toggle(300, 4);
        repeat (6) @(negedge clk);
        check("t3_300_pulses", vcnt - v0, 0);
        check("t3_300_locked", int'(locked), 0);

        // 4: loss of signal
        do_reset();
        toggle(5, 4);
        t_tog = cyc;
        s0 = scnt;
        repeat (530) @(negedge clk);
        check("t4_silent_cnt", scnt - s0, 1);
        check("t4_silent_time", t_sil - t_tog, c_S + 513);
        check("t4_locked", int'(locked), 0);
        check("t4_preset", int'(meas_preset), 4);

        // 5: alternating 5/6 never locks
        do_reset();
        v0 = vcnt;
        for (int i = 0; i < 4; i++) begin
            toggle(5, 1);
            toggle(6, 1);
        end
        repeat (8) @(negedge clk);
        check("t5_pulses", vcnt - v0, 0);
        check("t5_locked", int'(locked), 0);

        // 6: reset while locked
        do_reset();
        toggle(3, 4);
        repeat (6) @(negedge clk);
        check("t6_pre_locked", int'(locked), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_preset", int'(meas_preset), 0);
        check("t6_rst_locked", int'(locked), 0);
        check("t6_rst_valid", int'(preset_valid), 0);
        check("t6_rst_silent", int'(silent), 0);
        rst = 1'b0;
        v0 = vcnt;
        toggle(3, 2);
        toggle(3, 1);
        check("t6_two_edges", int'(locked), 0);
        repeat (6) @(negedge clk);
        check("t6_relock", int'(locked), 1);
        check("t6_pulses", vcnt - v0, 1);
        check("t6_preset", int'(meas_preset), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
